// File: rtl/conv_mem_pkg.sv
// Shared types and default constants for the convolution scratch memory.
package conv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } cm_state_t;

    localparam int CM_DATA_W = 8;
    localparam int CM_ROW_AW = 3;
    localparam int CM_COL_AW = 8;

    localparam int CM_SRC_A_ROW = 0;
    localparam int CM_SRC_B_ROW = 1;
    localparam int CM_DST_ROW   = 2;

endpackage

// File: rtl/conv_mem_mul.sv
// Element multiplier; CONV_MEM_SAT_MUL_EN selects saturation
// instead of truncation to DATA_W bits.
module conv_mem_mul #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] p
);

    logic [2*DATA_W-1:0] full;

    assign full = a * b;

`ifdef CONV_MEM_SAT_MUL_EN
    assign p = (|full[2*DATA_W-1:DATA_W]) ? '1 : full[DATA_W-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^full[2*DATA_W-1:DATA_W];
    assign p = full[DATA_W-1:0];
`endif

endmodule

// File: rtl/conv_mem_8x256.sv
// Byte scratch memory with an element-wise multiply engine.
// Build option: CONV_MEM_SAT_MUL_EN (saturating products).
module conv_mem_8x256
    import conv_mem_pkg::*;
#(
    parameter int DATA_W    = CM_DATA_W,
    parameter int ROW_AW    = CM_ROW_AW,
    parameter int COL_AW    = CM_COL_AW,
    parameter int VEC_LEN   = 256,
    parameter int SRC_A_ROW = CM_SRC_A_ROW,
    parameter int SRC_B_ROW = CM_SRC_B_ROW,
    parameter int DST_ROW   = CM_DST_ROW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              En,
    input  logic [ROW_AW-1:0] Row_ADDRS,
    input  logic [COL_AW-1:0] Col_ADDRS,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Write,
    input  logic              READ,
    output logic [DATA_W-1:0] DataOut,
    output logic              DONE
);

    localparam int NROWS = 2 ** ROW_AW;
    localparam int NCOLS = 2 ** COL_AW;
    localparam logic [COL_AW-1:0] LAST = COL_AW'(VEC_LEN - 1);

    logic [DATA_W-1:0] mem [NROWS][NCOLS];

    cm_state_t         state, state_nxt;
    logic [COL_AW-1:0] idx, idx_nxt;
    logic              done_q, done_nxt;
    logic [DATA_W-1:0] prod;

    conv_mem_mul #(
        .DATA_W(DATA_W)
    ) u_mul (
        .a(mem[SRC_A_ROW][idx]),
        .b(mem[SRC_B_ROW][idx]),
        .p(prod)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = done_q;
        unique case (state)
            ST_IDLE: begin
                if (En) begin
                    state_nxt = ST_BUSY;
                    idx_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (idx == LAST) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            ST_DONE: begin
                if (!En) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            done_q <= done_nxt;
        end
    end

    // The engine owns the array while busy; host writes are dropped then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NROWS; r++) begin
                for (int c = 0; c < NCOLS; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (state == ST_BUSY) begin
            mem[DST_ROW][idx] <= prod;
        end else if (Write) begin
            mem[Row_ADDRS][Col_ADDRS] <= DataIn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DataOut <= '0;
        end else if (READ) begin
            DataOut <= mem[Row_ADDRS][Col_ADDRS];
        end
    end

    assign DONE = done_q;

endmodule

// File: tb/tb_conv_mem_8x256.sv
// Directed bench for conv_mem_8x256 with a 5-column compute run.
// Expected products depend on CONV_MEM_SAT_MUL_EN.
module tb_conv_mem_8x256;

    logic       clk;
    logic       rst_n;
    logic       En;
    logic [2:0] Row_ADDRS;
    logic [7:0] Col_ADDRS;
    logic [7:0] DataIn;
    logic       Write;
    logic       READ;
    logic [7:0] DataOut;
    logic       DONE;

    int n_vec;
    int n_bad;

    conv_mem_8x256 #(
        .VEC_LEN(5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .En       (En),
        .Row_ADDRS(Row_ADDRS),
        .Col_ADDRS(Col_ADDRS),
        .DataIn   (DataIn),
        .Write    (Write),
        .READ     (READ),
        .DataOut  (DataOut),
        .DONE     (DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input int c, input int d);
        Row_ADDRS = 3'(r);
        Col_ADDRS = 8'(c);
        DataIn    = 8'(d);
        Write     = 1'b1;
        tick();
        Write     = 1'b0;
    endtask

    task automatic rd(input int r, input int c, output int d);
        Row_ADDRS = 3'(r);
        Col_ADDRS = 8'(c);
        READ      = 1'b1;
        tick();
        READ      = 1'b0;
        d         = int'(DataOut);
    endtask

    // Raise En, count edges until DONE; bounded so a stuck FSM still ends.
    task automatic run_vec(output int cyc);
        En = 1'b1;
        tick();
        cyc = 0;
        while (!DONE && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    int d;
    int cyc;
    int sq[5] = '{0, 1, 4, 9, 16};
`ifdef CONV_MEM_SAT_MUL_EN
    int p20 = 255;
    int p255x2 = 255;
`else
    int p20 = 144;
    int p255x2 = 254;
`endif

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        En        = 1'b0;
        Row_ADDRS = '0;
        Col_ADDRS = '0;
        DataIn    = '0;
        Write     = 1'b0;
        READ      = 1'b0;
        #12;
        check("rst_done", 32'(DONE), 0);
        check("rst_dout", 32'(DataOut), 0);
        rst_n = 1'b1;

        rd(3, 7, d);
        check("rd_r3c7", d, 0);
        check("idle_done", 32'(DONE), 0);

        for (int i = 0; i < 5; i++) begin
            wr(0, i, i);
            wr(1, i, i);
        end
        rd(1, 3, d);
        check("rd_r1c3", d, 3);
        tick();
        check("dout_hold", 32'(DataOut), 3);

        // Same-edge read and write of one address returns the old word.
        Row_ADDRS = 3'd5;
        Col_ADDRS = 8'd0;
        DataIn    = 8'd9;
        Write     = 1'b1;
        READ      = 1'b1;
        tick();
        Write     = 1'b0;
        READ      = 1'b0;
        check("rbw_old", 32'(DataOut), 0);
        rd(5, 0, d);
        check("rbw_new", d, 9);

        // Compute run with a host write attempted during BUSY.
        En = 1'b1;
        tick();
        Row_ADDRS = 3'd0;
        Col_ADDRS = 8'd0;
        DataIn    = 8'd77;
        Write     = 1'b1;
        cyc = 0;
        while (!DONE && cyc < 20) begin
            tick();
            Write = 1'b0;
            cyc++;
        end
        check("lat1", cyc, 5);
        repeat (3) tick();
        check("done_hold", 32'(DONE), 1);
        En = 1'b0;
        tick();
        check("done_drop", 32'(DONE), 0);
        for (int i = 0; i < 5; i++) begin
            rd(2, i, d);
            check($sformatf("sq%0d", i), d, sq[i]);
        end
        rd(2, 5, d);
        check("r2c5_untouched", d, 0);
        rd(0, 0, d);
        check("busy_wr_ignored", d, 0);

        // Overflowing products.
        wr(0, 0, 20);
        wr(1, 0, 20);
        wr(0, 1, 255);
        wr(1, 1, 2);
        run_vec(cyc);
        check("lat2", cyc, 5);
        En = 1'b0;
        tick();
        rd(2, 0, d);
        check("p20x20", d, p20);
        rd(2, 1, d);
        check("p255x2", d, p255x2);
        rd(2, 4, d);
        check("p4x4", d, 16);

        // Reset partway through a run.
        rd(0, 0, d);
        check("pre_rst_dout", d, 20);
        En = 1'b1;
        tick();
        En = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_done", 32'(DONE), 0);
        check("midrst_dout", 32'(DataOut), 0);
        #2;
        rst_n = 1'b1;
        rd(2, 0, d);
        check("post_rst_r2c0", d, 0);
        rd(0, 1, d);
        check("post_rst_r0c1", d, 0);

        wr(0, 2, 3);
        wr(1, 2, 7);
        run_vec(cyc);
        check("lat3", cyc, 5);
        En = 1'b0;
        tick();
        check("done_drop3", 32'(DONE), 0);
        rd(2, 2, d);
        check("p3x7", d, 21);
        rd(2, 0, d);
        check("p0x0", d, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_mem_8x256.md
Name: conv_mem_8x256

Overview:
- Byte-wide scratch memory: 8 rows x 256 columns of 8-bit words, for the convolution engine datapath.
- Host writes two operand vectors into fixed source rows (row 0, row 1).
- Host pulses En; the block computes an element-wise product into the destination row (row 2) and raises DONE.
- Host then reads results back through the same row/column addressed port.

Parameters:
- DATA_W, 8, word width.
- ROW_AW, 3, row address width (2^ROW_AW rows).
- COL_AW, 8, column address width (2^COL_AW columns).
- VEC_LEN, 256, number of columns processed per compute run (1..2^COL_AW).
- SRC_A_ROW, 0, first operand row.
- SRC_B_ROW, 1, second operand row.
- DST_ROW, 2, result row.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- En  in  1  compute request (level); a run starts when sampled high in IDLE.
- Row_ADDRS  in  ROW_AW  host row address.
- Col_ADDRS  in  COL_AW  host column address.
- DataIn  in  DATA_W  host write data.
- Write  in  1  host write strobe.
- READ  in  1  host read strobe.
- DataOut  out  DATA_W  registered read data.
- DONE  out  1  compute-complete flag.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, column index=0, DataOut=0, DONE=0, all memory words cleared to 0.
- Host write: at a rising edge with Write=1 and FSM≠BUSY, mem[Row_ADDRS][Col_ADDRS] <= DataIn. Write is ignored while BUSY.
- Host read: at a rising edge with READ=1, DataOut <= mem[Row_ADDRS][Col_ADDRS]. One-cycle latency; allowed in any state.
  - DataOut holds its last value when READ=0.
  - Simultaneous READ and Write to the same address return the old word (read-before-write).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: En=1 at an edge -> BUSY, idx<=0.
  - BUSY: each edge, mem[DST_ROW][idx] <= (mem[SRC_A_ROW][idx] * mem[SRC_B_ROW][idx]) truncated to low DATA_W bits, then idx++. After writing idx=VEC_LEN-1 -> DONE.
  - DONE: DONE=1 (registered). Stays in DONE while En=1. En=0 -> IDLE, and DONE drops on that edge.
- Latency: En sampled at edge k; results are written on edges k+1..k+VEC_LEN; DONE is high after edge k+VEC_LEN.
- En deasserted mid-BUSY has no effect; the run completes.
- Reset mid-run aborts the run and clears all state and memory.
- Host reads of DST_ROW during BUSY return whatever the row holds at that edge.
- idx never wraps past VEC_LEN-1. Columns >= VEC_LEN of DST_ROW are untouched.
- Product uses the full 2*DATA_W-bit product internally; only the low DATA_W bits are stored.

Optional Feature:
- Macro CONV_MEM_SAT_MUL_EN.
  - Defined: products above 2^DATA_W-1 store 2^DATA_W-1 (saturate, e.g. 20*20 -> 255).
  - Undefined: low DATA_W bits are stored (20*20=400 -> 144).

Decomposition:
- Package conv_mem_pkg:
  - FSM state enum (IDLE/BUSY/DONE).
  - Default width constants DATA_W/ROW_AW/COL_AW.
  - Default row-role constants SRC_A_ROW/SRC_B_ROW/DST_ROW.
- One sub-module, conv_mem_mul: combinational DATA_W x DATA_W multiply with truncate or saturate selected by the macro.
- Memory array and FSM stay in the top.

Test Plan:
- Reset then read (row 3, col 7) -> DataOut=0; DONE=0.
- Write row0 cols0..4 = 0..4 and row1 cols0..4 = 0..4; read back row1 col3 -> DataOut=3 one cycle after READ.
- VEC_LEN=5: with the vectors above, raise En -> DONE rises exactly 5 edges after En is sampled; read row2 cols0..4 -> 0,1,4,9,16; row2 col5 stays 0.
- Hold En high after DONE -> DONE stays 1; drop En -> DONE=0 next edge and FSM back to IDLE. Write during BUSY to row0 col0 -> ignored (reads back old value).
- Operands 20,20 at col0 -> row2 col0 = 144 (macro undefined) / 255 (CONV_MEM_SAT_MUL_EN defined).
- Assert rst_n=0 mid-BUSY -> DONE=0, DataOut=0 immediately; after release, row2 reads 0 and a new En run completes normally.
